// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer for the pipelined LC-3b: byte lane steering,
// LDI/STI pointer indirection and pipeline stall until each access completes.

package lc3b_types;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       is_ldi;
    logic       is_sti;
  } lc3b_control_word;
endpackage

module mem_access_unit
  import lc3b_types::*;
#(
  parameter bit INDIRECT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  lc3b_control_word in_ctrl,
  input  logic [15:0]      in_addr,
  input  logic [15:0]      in_wdata,
  output logic [15:0]      dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [15:0]      dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  input  logic [15:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             mem_stall,
  output logic             mem_done,
  output logic [15:0]      wb_data
);

  // state | meaning
  // IDLE  | no access in flight; capture a new memory op
  // IND   | pointer read for LDI/STI
  // ACC   | final data access (read or write)
  // DONE  | one-cycle completion; same instruction still on inputs
  typedef enum logic [1:0] {IDLE, IND, ACC, DONE} state_t;

  state_t           state_q, state_d;
  lc3b_control_word ctrl_q;
  logic [15:0]      addr_q, data_q, ptr_q;

  logic        mem_op, want_ind, via_ind, word_op, is_rd, is_wr;
  logic [15:0] acc_base, acc_addr;
  logic [1:0]  lane_be;
  logic [7:0]  rd_byte;

  assign mem_op   = in_valid & (in_ctrl.mem_read | in_ctrl.mem_write);
  assign want_ind = INDIRECT_EN & (in_ctrl.is_ldi | in_ctrl.is_sti);
  assign via_ind  = INDIRECT_EN & (ctrl_q.is_ldi | ctrl_q.is_sti);
  assign word_op  = (ctrl_q.mem_byte_enable == 2'b11);
  // Read wins if both strobes were requested.
  assign is_rd    = ctrl_q.mem_read;
  assign is_wr    = ctrl_q.mem_write & ~ctrl_q.mem_read;

  assign acc_base = via_ind ? ptr_q : addr_q;
  assign acc_addr = word_op ? {acc_base[15:1], 1'b0} : acc_base;
  assign lane_be  = acc_base[0] ? 2'b10 : 2'b01;
  assign rd_byte  = acc_base[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

  always_comb begin
    state_d          = state_q;
    dmem_address     = 16'h0000;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_wdata       = 16'h0000;
    dmem_byte_enable = 2'b00;
    mem_stall        = 1'b0;
    mem_done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          state_d   = want_ind ? IND : ACC;
        end
      end
      IND: begin
        mem_stall        = 1'b1;
        dmem_read        = 1'b1;
        dmem_address     = {addr_q[15:1], 1'b0};
        dmem_byte_enable = 2'b11;
        if (dmem_resp) state_d = ACC;
      end
      ACC: begin
        mem_stall        = 1'b1;
        dmem_address     = acc_addr;
        dmem_byte_enable = word_op ? 2'b11 : lane_be;
        if (is_rd) begin
          dmem_read = 1'b1;
        end else if (is_wr) begin
          dmem_write = 1'b1;
          dmem_wdata = word_op ? data_q : {data_q[7:0], data_q[7:0]};
        end
        if (dmem_resp) state_d = DONE;
      end
      DONE: begin
        mem_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      ptr_q   <= 16'h0000;
      wb_data <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_op) begin
        ctrl_q <= in_ctrl;
        addr_q <= in_addr;
        data_q <= in_wdata;
      end
      if (state_q == IND && dmem_resp) ptr_q <= dmem_rdata;
      if (state_q == ACC && dmem_resp && is_rd)
        wb_data <= word_op ? dmem_rdata : {8'h00, rd_byte};
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random ops, each checked
// cycle by cycle against a transaction-level model of accesses and latency.

module tb_mem_access_unit;
  import lc3b_types::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  lc3b_control_word in_ctrl;
  logic [15:0]      in_addr, in_wdata;
  logic [15:0]      dmem_address, dmem_wdata, dmem_rdata, wb_data;
  logic             dmem_read, dmem_write, dmem_resp, mem_stall, mem_done;
  logic [1:0]       dmem_byte_enable;

  mem_access_unit #(.INDIRECT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_addr(in_addr), .in_wdata(in_wdata), .dmem_address(dmem_address),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .mem_stall(mem_stall), .mem_done(mem_done),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];
  int          k_lat = 1;
  int          cnt = 0;
  bit          force_resp = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] wb_model = 16'h0000;
  logic [15:0] last_addr, last_wd;
  logic [1:0]  last_be;
  int          stall_cnt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endfunction

  function automatic lc3b_control_word mk(bit rd, bit wr, logic [1:0] be, bit ldi, bit sti);
    lc3b_control_word w;
    w.mem_read = rd; w.mem_write = wr; w.mem_byte_enable = be;
    w.is_ldi = ldi; w.is_sti = sti;
    return w;
  endfunction

  // Memory: responds k cycles into a held strobe; random rdata otherwise.
  always @(negedge clk) begin
    logic [15:0] w;
    if (dmem_read || dmem_write) cnt++; else cnt = 0;
    if ((dmem_read || dmem_write) && cnt == k_lat) begin
      dmem_resp = 1'b1;
      cnt = 0;
      if (dmem_read) dmem_rdata = mem[dmem_address[15:1]];
      else begin
        w = mem[dmem_address[15:1]];
        if (dmem_byte_enable[1]) w[15:8] = dmem_wdata[15:8];
        if (dmem_byte_enable[0]) w[7:0]  = dmem_wdata[7:0];
        mem[dmem_address[15:1]] = w;
        dmem_rdata = 16'($urandom);
      end
    end else begin
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
    end
    if (force_resp) dmem_resp = 1'b1;
  end

  task automatic run_op(input bit v, input lc3b_control_word c, input logic [15:0] a,
                        input logic [15:0] d, input int k);
    int n, last, j;
    bit rd_a [2];
    logic [15:0] ad_a [2];
    logic [1:0]  be_a [2];
    logic [15:0] wd_a [2];
    logic [15:0] base, w, old_wb, new_wb, exp_wb;
    bit memop, ind, word, exp_str;
    memop = v && (c.mem_read || c.mem_write);
    ind   = memop && (c.is_ldi || c.is_sti);
    word  = (c.mem_byte_enable == 2'b11);
    n = 0; base = a;
    if (ind) begin
      rd_a[0] = 1'b1; ad_a[0] = a & 16'hFFFE; be_a[0] = 2'b11; wd_a[0] = 16'h0;
      base = mem[a[15:1]];
      n = 1;
    end
    if (memop) begin
      rd_a[n] = c.mem_read;
      ad_a[n] = word ? (base & 16'hFFFE) : base;
      be_a[n] = word ? 2'b11 : (base[0] ? 2'b10 : 2'b01);
      wd_a[n] = word ? d : {d[7:0], d[7:0]};
      n++;
    end
    old_wb = wb_model;
    new_wb = old_wb;
    if (memop && c.mem_read) begin
      w = mem[base[15:1]];
      new_wb = word ? w : {8'h00, (base[0] ? w[15:8] : w[7:0])};
    end
    k_lat = k;
    stall_cnt = 0;
    last = memop ? n * k + 1 : 1;
    for (int cy = 0; cy <= last; cy++) begin
      if (cy == 0) begin
        @(posedge clk); #1;
        in_valid = v; in_ctrl = c; in_addr = a; in_wdata = d;
        #1;
      end else begin
        @(posedge clk); #2;
      end
      exp_str = memop && cy >= 1 && cy <= n * k;
      j = exp_str ? (cy - 1) / k : 0;
      chk("mem_stall", mem_stall, memop && cy <= n * k);
      chk("mem_done", mem_done, memop && cy == n * k + 1);
      chk("dmem_read", dmem_read, exp_str && rd_a[j]);
      chk("dmem_write", dmem_write, exp_str && !rd_a[j]);
      if (exp_str) begin
        chk("dmem_address", dmem_address, ad_a[j]);
        chk("dmem_byte_enable", dmem_byte_enable, be_a[j]);
        if (!rd_a[j]) chk("dmem_wdata", dmem_wdata, wd_a[j]);
        last_addr = dmem_address; last_be = dmem_byte_enable; last_wd = dmem_wdata;
      end
      exp_wb = (memop && cy == n * k + 1) ? new_wb : old_wb;
      chk("wb_data", wb_data, exp_wb);
      if (mem_stall) stall_cnt++;
    end
    wb_model = new_wb;
  endtask

  initial begin
    logic [15:0] rv;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_addr = '0; in_wdata = '0;
    dmem_resp = 1'b0; dmem_rdata = '0;
    #1;
    chk("rst dmem_read", dmem_read, 1'b0);
    chk("rst dmem_write", dmem_write, 1'b0);
    chk("rst dmem_address", dmem_address, 16'h0);
    chk("rst dmem_wdata", dmem_wdata, 16'h0);
    chk("rst byte_enable", dmem_byte_enable, 2'b00);
    chk("rst mem_done", mem_done, 1'b0);
    chk("rst wb_data", wb_data, 16'h0);
    chk("rst mem_stall", mem_stall, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LDR word, odd address aligned down
    mem[16'h3004 >> 1] = 16'hBEEF;
    run_op(1, mk(1, 0, 2'b11, 0, 0), 16'h3005, 16'h0, 2);
    chk("ldr wb literal", wb_data, 16'hBEEF);
    chk("ldr addr literal", last_addr, 16'h3004);
    chk("ldr be literal", last_be, 2'b11);
    chk("ldr stall cycles", stall_cnt, 3);

    // LDB high and low lanes
    mem[16'h1000 >> 1] = 16'hA55A;
    run_op(1, mk(1, 0, 2'b01, 0, 0), 16'h1001, 16'h0, 1);
    chk("ldb hi wb literal", wb_data, 16'h00A5);
    chk("ldb hi be literal", last_be, 2'b10);
    run_op(1, mk(1, 0, 2'b01, 0, 0), 16'h1000, 16'h0, 3);
    chk("ldb lo wb literal", wb_data, 16'h005A);
    chk("ldb lo be literal", last_be, 2'b01);

    // STB to odd address
    mem[16'h2002 >> 1] = 16'h0000;
    run_op(1, mk(0, 1, 2'b01, 0, 0), 16'h2003, 16'h12C4, 2);
    chk("stb wdata literal", last_wd, 16'hC4C4);
    chk("stb addr literal", last_addr, 16'h2003);
    chk("stb be literal", last_be, 2'b10);
    chk("stb mem literal", mem[16'h2002 >> 1], 16'hC400);
    chk("stb wb unchanged", wb_data, 16'h005A);

    // LDI / STI
    mem[16'h4000 >> 1] = 16'h5002;
    mem[16'h5002 >> 1] = 16'h7777;
    run_op(1, mk(1, 0, 2'b11, 1, 0), 16'h4000, 16'h0, 1);
    chk("ldi wb literal", wb_data, 16'h7777);
    chk("ldi stall cycles", stall_cnt, 3);
    run_op(1, mk(0, 1, 2'b11, 0, 1), 16'h4000, 16'h1234, 1);
    chk("sti mem literal", mem[16'h5002 >> 1], 16'h1234);
    chk("sti addr literal", last_addr, 16'h5002);

    // Non-memory op, with a stray response that must be ignored
    force_resp = 1'b1;
    run_op(1, mk(0, 0, 2'b11, 0, 0), 16'h0123, 16'h4567, 1);
    force_resp = 1'b0;
    @(negedge clk);
    chk("add stall cycles", stall_cnt, 0);

    // Back-to-back loads
    run_op(1, mk(1, 0, 2'b11, 0, 0), 16'h0100, 16'h0, 2);
    run_op(1, mk(1, 0, 2'b11, 0, 0), 16'h0102, 16'h0, 1);

    // Reset during the pointer read of an LDI
    k_lat = 3;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ctrl = mk(1, 0, 2'b11, 1, 0); in_addr = 16'h4000; in_wdata = '0;
    @(posedge clk); #2;
    chk("ind strobe before reset", dmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset drops read", dmem_read, 1'b0);
    chk("reset drops write", dmem_write, 1'b0);
    chk("reset wb_data", wb_data, 16'h0);
    wb_model = 16'h0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem[16'h0600 >> 1] = 16'h2468;
    run_op(1, mk(1, 0, 2'b11, 0, 0), 16'h0600, 16'h0, 2);
    chk("post-reset ldr literal", wb_data, 16'h2468);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      int op;
      lc3b_control_word c;
      logic [1:0] bb;
      bit v;
      op = $urandom_range(0, 7);
      bb = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      v  = ($urandom_range(0, 9) != 0);
      rv = 16'($urandom);
      case (op)
        0: c = mk(1, 0, 2'b11, 0, 0);
        1: c = mk(0, 1, 2'b11, 0, 0);
        2: c = mk(1, 0, bb, 0, 0);
        3: c = mk(0, 1, bb, 0, 0);
        4: c = mk(1, 0, 2'b11, 1, 0);
        5: c = mk(0, 1, 2'b11, 0, 1);
        6: c = mk(0, 0, 2'b11, 0, 0);
        default: c = mk(1, 1, 2'($urandom), 0, 0);
      endcase
      run_op(v, c, 16'($urandom), rv, $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory sequencer for the pipelined LC-3b. It consumes the EX/MEM pipeline register (lc3b_control_word, ALU address, store data) and drives the data-memory/L1 D-cache request interface. It performs byte lane steering for LDB/STB and the two-access sequence for LDI/STI, stalls the pipeline until each access completes, and delivers the load result to MEM/WB.

Parameters:
INDIRECT_EN, 1, 1 = LDI/STI perform a pointer read then the final access; 0 = treat is_ldi/is_sti as plain LDR/STR.

Ports:
clk  in  1  pipeline clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM register holds a valid instruction
in_ctrl  in  lc3b_control_word  control word from EX/MEM (mem_read, mem_write, mem_byte_enable, is_ldi, is_sti used)
in_addr  in  16  effective address (ALU result)
in_wdata  in  16  store data (SR value)
dmem_address  out  16  memory address
dmem_read  out  1  read strobe, held until dmem_resp
dmem_write  out  1  write strobe, held until dmem_resp
dmem_wdata  out  16  write data
dmem_byte_enable  out  2  lane mask, bit1 = [15:8]
dmem_rdata  in  16  read data, valid with dmem_resp
dmem_resp  in  1  one-cycle completion pulse
mem_stall  out  1  freeze IF..EX/MEM registers this cycle
mem_done  out  1  one-cycle pulse: access complete, wb_data valid
wb_data  out  16  load result to MEM/WB

Behaviour:
- Memory op = in_valid & (mem_read | mem_write). Word op: mem_byte_enable==2'b11. Otherwise it is a byte op.
- FSM states: IDLE, IND, ACC, DONE. Reset value: IDLE.
- IDLE:
  - If memory op: capture in_ctrl, in_addr and in_wdata into internal registers (ctrl_q, addr_q, data_q).
  - Go to IND if INDIRECT_EN & (is_ldi | is_sti); otherwise go to ACC.
  - No strobes are driven in IDLE.
- IND:
  - dmem_read=1, dmem_address={addr_q[15:1],1'b0}, byte_enable=2'b11.
  - On dmem_resp: ptr_q <= dmem_rdata, then go to ACC.
- ACC address:
  - Base a = ptr_q if the op went through IND, else addr_q.
  - Word op: {a[15:1],0}.
  - Byte op: a, unmodified.
- ACC read:
  - dmem_read=1.
  - Word op: byte_enable=11.
  - Byte op: byte_enable = a[0] ? 10 : 01.
  - On dmem_resp: wb_data <= word op ? dmem_rdata : {8'h00, a[0] ? rdata[15:8] : rdata[7:0]}.
- ACC write:
  - dmem_write=1.
  - Word op: wdata=data_q, byte_enable=11.
  - Byte op: wdata={data_q[7:0],data_q[7:0]}, byte_enable = a[0] ? 10 : 01.
  - On dmem_resp, wb_data is unchanged.
- On dmem_resp in ACC: go to DONE.
- DONE:
  - mem_done=1, no strobes.
  - Go to IDLE unconditionally. The same instruction is still on the inputs this cycle and must not be re-issued.
- mem_stall is combinational: (IDLE & memory op) | IND | ACC. It is 0 in DONE and for non-memory ops.
- Latency with memory response latency k (resp k cycles after the strobe rises, k≥1):
  - Plain op: stalled for 1 + k cycles, mem_done in the following cycle.
  - Indirect op: stalled for 1 + 2k cycles.
- Strobes, address, byte_enable and wdata are stable while a strobe is high. At most one of dmem_read/dmem_write is high.
- mem_read & mem_write both set is illegal; the block gives read priority.
- dmem_resp outside IND/ACC is ignored.
- Reset outputs: strobes 0, dmem_address 0, dmem_wdata 0, byte_enable 00, mem_done 0, wb_data 0, ptr_q 0. mem_stall follows its combinational equation.
- rst_n low mid-access (IND/ACC) abandons the access at once: strobes drop asynchronously and the state returns to IDLE.
- wb_data holds its value until the next completed read.

Test Plan:
1. LDR word, in_addr=0x3005, memory returns 0xBEEF with k=2 → dmem_address=0x3004, byte_enable=11; mem_stall high 3 cycles; mem_done next cycle; wb_data=0xBEEF.
2. LDB, in_addr=0x1001, rdata=0xA55A → byte_enable=10, wb_data=0x00A5. Repeat with 0x1000 → byte_enable=01, wb_data=0x005A.
3. STB, in_addr=0x2003, in_wdata=0x12C4 → dmem_write=1, wdata=0xC4C4, byte_enable=10, address=0x2003; wb_data unchanged.
4. LDI, in_addr=0x4000, mem[0x4000]=0x5002, mem[0x5002]=0x7777, k=1 → read 0x4000 then read 0x5002; stall 3 cycles; wb_data=0x7777. Repeat as STI with data 0x1234 → the second access is a write of 0x1234 to 0x5002, byte_enable=11.
5. ADD with in_valid=1 → mem_stall=0, no strobes, mem_done=0. Back-to-back LDR,LDR → each access is issued exactly once, with no duplicate strobe in DONE.
6. Assert rst_n low during IND of an LDI → strobes drop within the same cycle, state is IDLE after release; the next LDR completes normally.
